xif_mem_responder: RTL and testbench
====================================

Name: xif_mem_responder

Overview:
- Memory-side responder for the CORE-V-XIF memory request/response and memory result interfaces.
- Accepts coprocessor load/store requests (mem_valid/mem_ready) and answers exceptions combinationally on mem_resp.
- Performs the access on an internal word-addressed array and returns mem_result a fixed LATENCY cycles later.
- Sits between rvfpm and the system/testbench memory; gives the FPU load/store path a cycle-accurate partner.

Parameters:
- X_ID_WIDTH, 4, width of the transaction id.
- X_MEM_WIDTH, 32, data width; also the array word width.
- MEM_DEPTH, 1024, number of array words; a power of two.
- LATENCY, 2, cycles from acceptance to mem_result_valid; legal range 1..8.
- BASE_ADDR, 32'h0000_0000, byte address of array word 0.

Ports:
- ck  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- mem_valid  in  1  request valid.
- mem_ready  out  1  request accepted when high together with mem_valid.
- mem_req_id  in  X_ID_WIDTH  request id.
- mem_req_addr  in  32  byte address.
- mem_req_we  in  1  1=store, 0=load.
- mem_req_size  in  3  0=byte, 1=half, 2=word.
- mem_req_be  in  X_MEM_WIDTH/8  store byte enables.
- mem_req_wdata  in  X_MEM_WIDTH  store data.
- mem_resp_exc  out  1  exception for the current request; combinational.
- mem_resp_exccode  out  6  exception code.
- mem_result_valid  out  1  one-cycle result strobe; no ready is defined.
- mem_result_id  out  X_ID_WIDTH  id of the returned transaction.
- mem_result_rdata  out  X_MEM_WIDTH  load data, full word.
- mem_result_err  out  1  bus error.
- dbg_addr  in  log2(MEM_DEPTH)  backdoor word index.
- dbg_rdata  out  X_MEM_WIDTH  combinational array[dbg_addr] for the bench.

Behaviour:
- Reset (rst=0, asynchronous): mem_ready=0, mem_result_valid=0, id/rdata/err=0, delay line cleared.
  - In-flight transactions are dropped. Array contents are retained.
  - mem_ready rises in the first cycle after rst deasserts.
- Acceptance: a transaction is accepted at a posedge ck with mem_valid && mem_ready. mem_ready=1 whenever out of reset (see Optional Feature).
- mem_resp is evaluated combinationally while mem_valid=1; it is 0 when mem_valid=0.
  - exc=1 if size>2, if size=1 and addr[0]=1, or if size=2 and addr[1:0]!=0.
  - exccode=6 for a store, 4 for a load.
  - An excepted transaction does not access the array and produces no mem_result.
- Index = (addr - BASE_ADDR) >> 2. Out of range means addr < BASE_ADDR or index >= MEM_DEPTH.
  - Out-of-range transaction: no array access; a result is still returned with err=1 and rdata=0.
- Store: at the accept edge, bytes with be[i]=1 are written; other bytes are unchanged. A store returns a result with rdata=0 and err=0.
- Load: the word is sampled at the accept edge. A store accepted in cycle N is visible to a load accepted in cycle N+1. Sub-word loads return the full word; the requester extracts lanes.
- Delay line: LATENCY-stage shift register of {valid, id, rdata, err}.
  - A transaction accepted at edge N drives mem_result_valid=1 for exactly the cycle after edge N+LATENCY-1; LATENCY=1 means valid the cycle after acceptance.
  - Back-to-back acceptances give back-to-back strobes in acceptance order; no reordering, no backpressure, throughput 1/cycle.
- Ids are not checked for uniqueness; duplicate ids are returned as given.
- Idle outputs: when mem_result_valid=0, id/rdata/err hold 0.

Optional Feature:
- Macro: XIF_MEM_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - mem_ready=0 in any cycle where lfsr[1:0]==2'b00.
  - Requests held under mem_valid must remain stable; acceptance and latency rules are otherwise unchanged.
  - Latency is counted from the accept edge.
- Undefined: no LFSR; mem_ready=1 whenever out of reset.

Test Plan:
- Store word 32'hDEAD_BEEF to 0x10 (id=3), then load 0x10 (id=4) the next cycle -> results id=3 rdata=0, then id=4 rdata=32'hDEAD_BEEF, each exactly LATENCY cycles after its accept.
- Store 32'h1122_3344 with be=4'b0101 over a word of 0 -> dbg_rdata=32'h0022_0044.
- Load size=2 at addr 0x6 -> mem_resp_exc=1, exccode=4 in the same cycle; no mem_result_valid over the following 10 cycles.
- Load at BASE_ADDR+4*MEM_DEPTH -> one result with err=1, rdata=0.
- Four back-to-back loads with ids 0..3, LATENCY=3 -> four consecutive strobes, ids 0,1,2,3, first strobe 3 cycles after the first accept.
- Assert rst with two transactions in flight -> no strobes occur; mem_ready=0 during reset and 1 the cycle after release; array data survives.

Source files
------------

// File: rtl/xif_mem_responder.sv
// CORE-V-XIF memory responder: word array with fixed-latency result path.
// Define XIF_MEM_RANDOM_STALL_EN to throttle mem_ready with a 16-bit LFSR.
module xif_mem_responder #(
    parameter int          X_ID_WIDTH  = 4,
    parameter int          X_MEM_WIDTH = 32,
    parameter int          MEM_DEPTH   = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    localparam int         AW          = $clog2(MEM_DEPTH),
    localparam int         BW          = X_MEM_WIDTH / 8
) (
    input  logic                   ck,
    input  logic                   rst,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [X_ID_WIDTH-1:0]  mem_req_id,
    input  logic [31:0]            mem_req_addr,
    input  logic                   mem_req_we,
    input  logic [2:0]             mem_req_size,
    input  logic [BW-1:0]          mem_req_be,
    input  logic [X_MEM_WIDTH-1:0] mem_req_wdata,
    output logic                   mem_resp_exc,
    output logic [5:0]             mem_resp_exccode,
    output logic                   mem_result_valid,
    output logic [X_ID_WIDTH-1:0]  mem_result_id,
    output logic [X_MEM_WIDTH-1:0] mem_result_rdata,
    output logic                   mem_result_err,
    input  logic [AW-1:0]          dbg_addr,
    output logic [X_MEM_WIDTH-1:0] dbg_rdata
);

    typedef struct packed {
        logic                   v;
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_MEM_WIDTH-1:0] rdata;
        logic                   err;
    } ent_t;

    logic [X_MEM_WIDTH-1:0] mem [MEM_DEPTH];
    ent_t                   dl  [LATENCY];
    ent_t                   nxt;

    logic        ready_q;
    logic [31:0] off;
    logic        oor;
    logic        misal;
    logic        acc;
    logic [AW-1:0] idx;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) ready_q <= 1'b0;
        else      ready_q <= 1'b1;
    end

`ifdef XIF_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr;
    logic        fb;

    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {lfsr[14:0], fb};
    end

    assign mem_ready = ready_q && (lfsr[1:0] != 2'b00);
`else
    assign mem_ready = ready_q;
`endif

    assign off = mem_req_addr - BASE_ADDR;
    assign idx = off[AW+1:2];
    assign oor = (mem_req_addr < BASE_ADDR)
              || ((off >> 2) >= 32'(MEM_DEPTH));

    assign misal = (mem_req_size > 3'd2)
                || (mem_req_size == 3'd1 && mem_req_addr[0])
                || (mem_req_size == 3'd2 && mem_req_addr[1:0] != 2'b00);

    assign mem_resp_exc     = mem_valid && misal;
    assign mem_resp_exccode = !mem_resp_exc ? 6'd0 :
                              mem_req_we    ? 6'd6 : 6'd4;

    assign acc = mem_valid && mem_ready && !misal;

    // Array has no reset so contents survive rst.
    always_ff @(posedge ck) begin
        if (acc && mem_req_we && !oor) begin
            for (int i = 0; i < BW; i++) begin
                if (mem_req_be[i])
                    mem[idx][8*i +: 8] <= mem_req_wdata[8*i +: 8];
            end
        end
    end

    assign dbg_rdata = mem[dbg_addr];

    always_comb begin
        nxt       = '0;
        nxt.v     = acc;
        nxt.id    = acc ? mem_req_id : '0;
        nxt.err   = acc && oor;
        nxt.rdata = (acc && !mem_req_we && !oor) ? mem[idx] : '0;
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) dl[i] <= '0;
        end else begin
            dl[0] <= nxt;
            for (int i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
        end
    end

    assign mem_result_valid = dl[LATENCY-1].v;
    assign mem_result_id    = dl[LATENCY-1].id;
    assign mem_result_rdata = dl[LATENCY-1].rdata;
    assign mem_result_err   = dl[LATENCY-1].err;

endmodule

// File: tb/tb_xif_mem_responder.sv
// Randomized bench for xif_mem_responder against an array/queue model.
// Results are predicted with a due-cycle per accepted transaction.
module tb_xif_mem_responder;

    localparam int          LAT   = 3;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [3:0]  mem_req_id = '0;
    logic [31:0] mem_req_addr = '0;
    logic        mem_req_we = 1'b0;
    logic [2:0]  mem_req_size = '0;
    logic [3:0]  mem_req_be = '0;
    logic [31:0] mem_req_wdata = '0;
    logic        mem_resp_exc;
    logic [5:0]  mem_resp_exccode;
    logic        mem_result_valid;
    logic [3:0]  mem_result_id;
    logic [31:0] mem_result_rdata;
    logic        mem_result_err;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_rdata;

    xif_mem_responder #(
        .X_ID_WIDTH (4),
        .X_MEM_WIDTH(32),
        .MEM_DEPTH  (DEPTH),
        .LATENCY    (LAT),
        .BASE_ADDR  (BASE)
    ) dut (
        .ck              (ck),
        .rst             (rst),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_req_id      (mem_req_id),
        .mem_req_addr    (mem_req_addr),
        .mem_req_we      (mem_req_we),
        .mem_req_size    (mem_req_size),
        .mem_req_be      (mem_req_be),
        .mem_req_wdata   (mem_req_wdata),
        .mem_resp_exc    (mem_resp_exc),
        .mem_resp_exccode(mem_resp_exccode),
        .mem_result_valid(mem_result_valid),
        .mem_result_id   (mem_result_id),
        .mem_result_rdata(mem_result_rdata),
        .mem_result_err  (mem_result_err),
        .dbg_addr        (dbg_addr),
        .dbg_rdata       (dbg_rdata)
    );

    always #5 ck = ~ck;

    typedef struct {
        int          due;
        logic [3:0]  id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [DEPTH];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    endtask

    always @(negedge ck) begin
        if (mon_en) begin
            if (!mem_valid) check("exc_idle", 64'(mem_resp_exc), 64'd0);
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                check("res_valid", 64'(mem_result_valid), 64'd1);
                check("res_id", 64'(mem_result_id), 64'(e.id));
                check("res_rdata", 64'(mem_result_rdata), 64'(e.rdata));
                check("res_err", 64'(mem_result_err), 64'(e.err));
            end else begin
                check("idle_valid", 64'(mem_result_valid), 64'd0);
                check("idle_fields",
                      {27'd0, mem_result_id, mem_result_rdata, mem_result_err},
                      64'd0);
            end
        end
    end

    task automatic idle(input int n);
        mem_valid = 1'b0;
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    // Drive one request; returns once the handshake completes.
    task automatic xfer(input logic [3:0] id, input logic [31:0] addr,
                        input logic we, input logic [2:0] sz,
                        input logic [3:0] be, input logic [31:0] wd);
        bit          rdy;
        bit          ex;
        bit          out;
        int          tries;
        int unsigned wi;
        exp_t        e;
        mem_valid     = 1'b1;
        mem_req_id    = id;
        mem_req_addr  = addr;
        mem_req_we    = we;
        mem_req_size  = sz;
        mem_req_be    = be;
        mem_req_wdata = wd;
        ex = (sz > 3'd2) || (sz == 3'd1 && addr[0])
          || (sz == 3'd2 && addr[1:0] != 2'b00);
        tries = 0;
        rdy = 1'b0;
        while (!rdy && tries < 100) begin
            @(negedge ck);
            check("exc", 64'(mem_resp_exc), 64'(ex));
            check("exccode", 64'(mem_resp_exccode),
                  ex ? (we ? 64'd6 : 64'd4) : 64'd0);
            rdy = mem_ready;
            @(posedge ck);
            #1;
            tries++;
        end
        if (!rdy) begin
            check("accept_timeout", 64'd0, 64'd1);
            return;
        end
        if (ex) return;
        out = (addr < BASE) || ((addr - BASE) / 4 >= DEPTH);
        wi  = (addr - BASE) / 4;
        e.due = cyc + LAT - 1;
        e.id  = id;
        e.err = out;
        e.rdata = 32'd0;
        if (!out) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[wi][8*b +: 8] = wd[8*b +: 8];
            end else begin
                e.rdata = mdl[wi];
            end
        end
        q.push_back(e);
    endtask

    task automatic peek(input int unsigned wi, input logic [31:0] exp,
                        input string tag);
        dbg_addr = wi[7:0];
        #1;
        check(tag, 64'(dbg_rdata), 64'(exp));
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int unsigned wi;

        repeat (2) @(negedge ck);
        check("rst_ready", 64'(mem_ready), 64'd0);
        check("rst_valid", 64'(mem_result_valid), 64'd0);
        check("rst_fields",
              {27'd0, mem_result_id, mem_result_rdata, mem_result_err}, 64'd0);
        rst = 1'b1;
        @(posedge ck);
        #1;
`ifndef XIF_MEM_RANDOM_STALL_EN
        check("ready_after_rst", 64'(mem_ready), 64'd1);
`endif
        mon_en = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            xfer(4'(i), 32'(4 * i), 1'b1, 3'd2, 4'hF, $urandom);
        idle(LAT + 1);

        xfer(4'd3, 32'h10, 1'b1, 3'd2, 4'hF, 32'hDEAD_BEEF);
        xfer(4'd4, 32'h10, 1'b0, 3'd2, 4'hF, 32'h0);
        idle(LAT + 1);
        peek(4, 32'hDEAD_BEEF, "store_word");

        xfer(4'd5, 32'h20, 1'b1, 3'd2, 4'hF, 32'h0);
        xfer(4'd6, 32'h20, 1'b1, 3'd2, 4'b0101, 32'h1122_3344);
        idle(1);
        peek(8, 32'h0022_0044, "byte_enable");

        xfer(4'd7, 32'h6, 1'b0, 3'd2, 4'hF, 32'h0);
        xfer(4'd8, 32'h3, 1'b1, 3'd1, 4'hF, 32'h0);
        idle(10);

        xfer(4'd9, BASE + 4 * DEPTH, 1'b0, 3'd2, 4'hF, 32'h0);
        idle(LAT + 1);

        for (int i = 0; i < 4; i++)
            xfer(4'(i), 32'(4 * i), 1'b0, 3'd2, 4'hF, 32'h0);
        idle(LAT + 1);

        xfer(4'd1, 32'h40, 1'b0, 3'd2, 4'hF, 32'h0);
        xfer(4'd2, 32'h44, 1'b0, 3'd2, 4'hF, 32'h0);
        mem_valid = 1'b0;
        #2;
        rst = 1'b0;
        q.delete();
        repeat (3) begin
            @(negedge ck);
            check("ready_in_rst", 64'(mem_ready), 64'd0);
        end
        rst = 1'b1;
        @(posedge ck);
        #1;
`ifndef XIF_MEM_RANDOM_STALL_EN
        check("ready_release", 64'(mem_ready), 64'd1);
`endif
        peek(4, mdl[4], "survive_rst");
        peek(8, mdl[8], "survive_rst2");

        for (int i = 0; i < 300; i++) begin
            wi = $urandom_range(0, DEPTH + 8);
            a  = 32'(4 * wi) + 32'($urandom_range(0, 3));
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                             : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            xfer(4'($urandom), a, 1'($urandom), sz, 4'($urandom), $urandom);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        idle(LAT + 2);
        check("drain", 64'(q.size()), 64'd0);
        for (int i = 0; i < 8; i++) begin
            wi = $urandom_range(0, DEPTH - 1);
            peek(wi, mdl[wi], "dbg_sweep");
        end
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
